pulse_handshake_tx: RTL and testbench

Source end of a four-phase req/ack pulse-transfer link. It turns single-cycle event pulses in the local clock domain into a held `req` level, which the far-side synchroniser detects as an edge. The acknowledgement arrives from the far domain as an asynchronous level and is synchronised internally. Events that arrive while a transfer is in flight are queued in a saturating counter and issued back-to-back.

---
 rtl/pulse_hs_pkg.sv | 14 +
 rtl/pulse_handshake_tx_if.sv | 34 +++
 rtl/pulse_handshake_tx_sync_ff.sv | 32 +++
 rtl/pulse_handshake_tx.sv | 114 +++++++++++
 tb/tb_pulse_handshake_tx.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/pulse_hs_pkg.sv
// Shared definitions for the pulse handshake link: FSM states and default sizes.
// Also used by the receive-side synchroniser bench.
package pulse_hs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 4;

endpackage

// File: rtl/pulse_handshake_tx_if.sv
// Handshake/status bundle between an event producer and pulse_handshake_tx.
// The master drives events and the far-side ack; the slave is the transmitter.
interface pulse_handshake_tx_if
  import pulse_hs_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             pulse_in;
  logic             ack_async;
  logic             req;
  logic             busy;
  logic [CNT_W-1:0] pend_cnt;
  logic             drop;

  modport master (
    output pulse_in,
    output ack_async,
    input  req,
    input  busy,
    input  pend_cnt,
    input  drop
  );

  modport slave (
    input  pulse_in,
    input  ack_async,
    output req,
    output busy,
    output pend_cnt,
    output drop
  );

endinterface

// File: rtl/pulse_handshake_tx_sync_ff.sv
// N-stage bit synchroniser, every stage cleared by synchronous reset.
// N must be at least 2.
module sync_ff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_stage [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) r_stage[gi] <= 1'b0;
          else     r_stage[gi] <= i_d;
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (rst) r_stage[gi] <= 1'b0;
          else     r_stage[gi] <= r_stage[gi-1];
        end
      end
    end
  endgenerate

  assign o_q = r_stage[N-1];

endmodule

// File: rtl/pulse_handshake_tx.sv
// Source end of a four-phase req/ack pulse link; queues events while busy.
// Define PULSE_TX_QUEUE_EN to build the saturating pending-event counter.
module pulse_handshake_tx
  import pulse_hs_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic                 clk,
  input logic                 rst,
  pulse_handshake_tx_if.slave hs
);

  state_t r_state;
  state_t w_state_next;
  logic   r_req;
  logic   r_drop;
  logic   w_drop_next;
  logic   w_ack_s;
  logic   w_launch;
  logic   w_queued;
  logic   w_avail;

  sync_ff #(.N(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .i_d (hs.ack_async),
    .o_q (w_ack_s)
  );

`ifdef PULSE_TX_QUEUE_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_pend_cnt;
  logic [CNT_W-1:0] w_pend_next;
  logic             w_from_q;

  assign w_queued = (r_pend_cnt != '0);
  assign w_from_q = w_launch & w_queued;

  // Queue has priority over pulse_in, so a pulse coinciding with a queued launch nets to zero.
  always_comb begin
    w_pend_next = r_pend_cnt;
    w_drop_next = 1'b0;
    if (w_from_q && !hs.pulse_in) begin
      w_pend_next = r_pend_cnt - 1'b1;
    end else if (hs.pulse_in && !w_launch) begin
      if (r_pend_cnt == CNT_MAX) w_drop_next = 1'b1;
      else                       w_pend_next = r_pend_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_pend_cnt <= '0;
    else     r_pend_cnt <= w_pend_next;
  end

  assign hs.pend_cnt = r_pend_cnt;
`else
  logic [CNT_W-1:0] w_pend_zero;

  assign w_queued    = 1'b0;
  assign w_pend_zero = '0;
  assign w_drop_next = hs.pulse_in & ~w_launch;
  assign hs.pend_cnt = w_pend_zero;
`endif

  assign w_avail = hs.pulse_in | w_queued;

  always_comb begin
    w_state_next = r_state;
    w_launch     = 1'b0;
    case (r_state)
      IDLE: begin
        // A stale ack left high (e.g. after reset) blocks launches until it clears.
        if (!w_ack_s && w_avail) begin
          w_state_next = REQ;
          w_launch     = 1'b1;
        end
      end
      REQ: begin
        if (w_ack_s) w_state_next = REL;
      end
      REL: begin
        if (!w_ack_s) begin
          if (w_avail) begin
            w_state_next = REQ;
            w_launch     = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_req   <= (w_state_next == REQ);
      r_drop  <= w_drop_next;
    end
  end

  assign hs.req  = r_req;
  assign hs.drop = r_drop;
  assign hs.busy = (r_state != IDLE) | w_ack_s;

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// Directed + randomized bench for pulse_handshake_tx against a req/ack-level reference model.
// Works with or without PULSE_TX_QUEUE_EN defined.
module tb_pulse_handshake_tx;

  localparam int SYNC  = 2;
  localparam int CNT_W = 4;
  localparam int MAXP  = (1 << CNT_W) - 1;
`ifdef PULSE_TX_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  pulse_handshake_tx_if #(.CNT_W(CNT_W)) bus ();

  pulse_handshake_tx #(.SYNC_STAGES(SYNC), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hs  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: request level, "released but ack not yet seen low" flag,
  // pending event count, drop flag, and the ack as seen after SYNC clock edges.
  bit m_req, m_rel, m_drop;
  int m_pend;
  bit m_ack_seen [$];

  // Receiver model: echoes the model request onto ack_async after a delay.
  bit rx_auto = 1'b0;
  bit rx_rand = 1'b0;
  bit rx_ack  = 1'b0;
  int rx_cnt  = 0;
  int rx_dly  = 3;

  bit prev_req = 1'b0;
  int dut_rises = 0;
  int dut_drops = 0;
  int peak_pend = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit p, input bit r, input bit a);
    bit ack_s, launch, from_q, have_q;
    if (r) begin
      m_req = 0; m_rel = 0; m_pend = 0; m_drop = 0;
      m_ack_seen = {};
      for (int i = 0; i < SYNC; i++) m_ack_seen.push_back(1'b0);
      return;
    end
    ack_s  = m_ack_seen[0];
    launch = 0;
    from_q = 0;
    have_q = QEN && (m_pend > 0);
    void'(m_ack_seen.pop_front());
    m_ack_seen.push_back(a);
    if (m_req) begin
      if (ack_s) begin m_req = 0; m_rel = 1; end
    end else if (!ack_s) begin
      if (p || have_q) begin launch = 1; from_q = have_q; m_req = 1; end
      m_rel = 0;
    end
    m_drop = 0;
    if (QEN) begin
      if (from_q) m_pend--;
      if (p && !(launch && !from_q)) begin
        if (m_pend == MAXP) m_drop = 1;
        else                m_pend++;
      end
    end else begin
      m_drop = p && !launch;
    end
  endtask

  function automatic bit model_busy();
    return m_req || m_rel || m_ack_seen[0];
  endfunction

  function automatic bit model_quiet();
    return !m_req && !m_rel && (m_pend == 0) && !rx_ack && !m_ack_seen[0];
  endfunction

  task automatic tick(input bit p, input bit r);
    @(negedge clk);
    if (rx_auto) begin
      if (rx_ack != m_req) begin
        rx_cnt++;
        if (rx_cnt >= rx_dly) begin
          rx_ack = m_req;
          rx_cnt = 0;
          if (rx_rand) rx_dly = $urandom_range(1, 4);
        end
      end else begin
        rx_cnt = 0;
      end
    end
    rst           = r;
    bus.pulse_in  = p;
    bus.ack_async = rx_ack;
    model_step(p, r, rx_ack);
    @(posedge clk);
    #1;
    chk("req", bus.req, m_req);
    chk("busy", bus.busy, model_busy());
    chk("pend_cnt", bus.pend_cnt, m_pend);
    chk("drop", bus.drop, m_drop);
    if (bus.req && !prev_req) dut_rises++;
    prev_req = bus.req;
    if (bus.drop) dut_drops++;
    if (int'(bus.pend_cnt) > peak_pend) peak_pend = int'(bus.pend_cnt);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (!model_quiet() && n < budget) begin
      tick(1'b0, 1'b0);
      n++;
    end
    chk({tag, "_drain_done"}, model_quiet(), 1);
    tick(1'b0, 1'b0);
    chk({tag, "_idle_busy"}, bus.busy, 0);
  endtask

  initial begin
    bus.pulse_in  = 1'b0;
    bus.ack_async = 1'b0;

    // Reset
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    chk("rst_req", bus.req, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pend", bus.pend_cnt, 0);
    chk("rst_drop", bus.drop, 0);

    // Single pulse, receiver echoes after 3 cycles
    rx_auto = 1; rx_rand = 0; rx_dly = 3;
    tick(1'b1, 1'b0);
    chk("launch_latency", bus.req, 1);
    drain("single", 100);
    chk("single_pend", bus.pend_cnt, 0);

    // Five consecutive pulses
    dut_rises = 0; peak_pend = 0;
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    drain("burst5", 300);
    chk("burst5_rises", dut_rises, QEN ? 5 : 1);
    chk("burst5_peak", peak_pend, QEN ? 4 : 0);

    // Twenty pulses with ack held low
    rx_auto = 0; rx_ack = 0; dut_drops = 0;
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
    chk("sat_pend", bus.pend_cnt, QEN ? MAXP : 0);
    chk("sat_drops", dut_drops, QEN ? 4 : 19);
    rx_auto = 1;
    drain("sat", 2000);

    // Queued launches colliding with fresh pulses
    rx_auto = 0; rx_ack = 0;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    rx_auto = 1; rx_dly = 2;
    for (int i = 0; i < 30; i++) tick(1'b1, 1'b0);
    drain("collide", 1000);

    // Randomized traffic with random receiver delays
    rx_rand = 1;
    for (int i = 0; i < 400; i++) tick(($urandom_range(0, 2) == 0), 1'b0);
    drain("random", 2000);

    // Reset while in REQ with ack high
    rx_auto = 0; rx_ack = 0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    rx_ack = 1;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    chk("midrst_req", bus.req, 0);
    chk("midrst_pend", bus.pend_cnt, 0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("stale_ack_busy", bus.busy, 1);
    tick(1'b1, 1'b0);
    chk("stale_ack_noreq", bus.req, 0);
    tick(1'b0, 1'b0);
    rx_ack = 0;
    dut_rises = 0;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
    chk("stale_ack_launch", dut_rises, QEN ? 1 : 0);
    rx_auto = 1;
    drain("midrst", 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
